cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- FSM that sequences the cache datapath for one requester.
- On each request it performs the tag lookup, then the hit access, or the miss recovery: dirty-victim writeback, line allocate, install and replay.
- Drives every cache-internal control strobe, the per-word handshake to the higher memory level and the line-word counter.
- Keeps saturating hit/miss/writeback statistics.

Parameters:
- LINE_SIZE, 32: bytes per line. WORDS_PER_LINE = LINE_SIZE/4, and the counter sequences that many words.
- READ_ONLY, 0: 1 = no dirty tracking and no writeback path (instruction cache).
- STAT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present. Address, size and store data held stable until req_done.
- req_op  in  1  0 = load, 1 = store
- req_done  out  1  one-cycle completion pulse
- hmem_req_valid  out  1  word transfer requested from higher memory
- hmem_req_op  out  1  0 = read word, 1 = write word
- hmem_req_done  in  1  current word accepted (write) or returned (read)
- valid_block_match  in  1  lookup hit
- valid_dirty_bit  in  1  selected victim is valid and dirty
- counter_done  in  1  word counter is at 0
- miss_recovery_mode  out  1  datapath steers counter, hmem data and word size
- set_hmem_block_address  out  1  latch hmem block address
- use_victim_tag_for_hmem_block_address  out  1  select victim tag instead of request tag
- clear_selected_valid_bit  out  1
- finish_new_line_install  out  1
- clear_selected_dirty_bit  out  1
- set_selected_dirty_bit  out  1
- perform_write  out  1  write the data array
- reset_counter  out  1  load counter with WORDS_PER_LINE-1
- decrement_counter  out  1
- hit_count  out  STAT_WIDTH  first-pass hits
- miss_count  out  STAT_WIDTH
- writeback_count  out  STAT_WIDTH

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE and the replay flag clears.
  - All strobes and req_done are 0; all statistics are 0.
  - Any in-flight hmem transfer is abandoned.
- Output style: all strobes are Moore/Mealy combinational on state and inputs, one cycle wide unless stated.
- IDLE: when req_valid=1, latch req_op and go to LOOKUP. Request inputs are ignored in every other state.
- LOOKUP, on a hit:
  - Load: req_done=1, go to IDLE.
  - Store: perform_write=1, set_selected_dirty_bit=1 (0 if READ_ONLY), req_done=1, go to IDLE.
  - READ_ONLY store: req_done=1 with no write.
  - If the replay flag is clear, hit_count increments. Clear the replay flag.
- LOOKUP, on a miss:
  - Always: miss_count increments, set_hmem_block_address=1, reset_counter=1.
  - If valid_dirty_bit=1 and READ_ONLY=0: use_victim_tag_for_hmem_block_address=1, go to WRITEBACK.
  - Otherwise: use_victim_tag_for_hmem_block_address=0, clear_selected_valid_bit=1, go to ALLOCATE.
  - A miss never occurs on replay; if valid_block_match=0 with the replay flag set, treat it as a new miss without incrementing miss_count.
- WRITEBACK:
  - miss_recovery_mode=1, hmem_req_valid=1, hmem_req_op=1.
  - On hmem_req_done with counter_done=0: decrement_counter.
  - On hmem_req_done with counter_done=1: clear_selected_dirty_bit=1, set_hmem_block_address=1 (request tag), reset_counter=1, clear_selected_valid_bit=1, writeback_count increments, go to ALLOCATE.
- ALLOCATE:
  - miss_recovery_mode=1, hmem_req_valid=1, hmem_req_op=0.
  - On hmem_req_done: perform_write=1.
  - If counter_done=0: decrement_counter.
  - Otherwise: finish_new_line_install=1, set the replay flag, go to LOOKUP.
- hmem handshake:
  - hmem_req_valid stays high with a stable op until hmem_req_done.
  - hmem_req_done may arrive in the same cycle as valid (zero wait).
  - hmem_req_done while hmem_req_valid=0 is ignored.
- Statistics saturate at all-ones and never wrap.
- Latency with zero-wait hmem and W = WORDS_PER_LINE:
  - Hit: req_done 1 cycle after req_valid is sampled in IDLE.
  - Clean miss: W+2 cycles.
  - Dirty miss: 2W+2 cycles.

Test Plan:
- Reset, then load hit (valid_block_match=1) → req_done in the cycle after req_valid; hit_count=1; no hmem activity.
- Store hit → perform_write and set_selected_dirty_bit pulse together with req_done; READ_ONLY=1 instance → perform_write=0, set_selected_dirty_bit=0.
- Clean load miss, W=8, zero-wait hmem:
  - exactly 8 hmem reads, 7 decrement_counter, 8 perform_write;
  - finish_new_line_install once, then the replay hit;
  - req_done at cycle 10; miss_count=1, hit_count=0.
- Dirty store miss, hmem_req_done every 3rd cycle:
  - 8 writes with use_victim=1 latched, then 8 reads;
  - clear_selected_dirty_bit once; writeback_count=1;
  - replay store writes and sets dirty.
- reset_n low during the 4th ALLOCATE word → immediate return to IDLE, all outputs 0; next request proceeds normally.
- STAT_WIDTH=2, 5 hits → hit_count holds at 3.

Source files
------------

// File: rtl/cache_controller_if.sv
// Request and higher-memory word handshake between the requester,
// the cache controller and the next memory level.
`timescale 1ns/1ps
interface cache_controller_if;
  logic req_valid;
  logic req_op;
  logic req_done;
  logic hmem_req_valid;
  logic hmem_req_op;
  logic hmem_req_done;

  // Controller side: takes requests, issues word transfers.
  modport slave (
    input  req_valid, req_op, hmem_req_done,
    output req_done, hmem_req_valid, hmem_req_op
  );

  // Environment side: requester plus higher memory.
  modport master (
    output req_valid, req_op, hmem_req_done,
    input  req_done, hmem_req_valid, hmem_req_op
  );
endinterface

// File: rtl/cache_controller.sv
// Cache controller FSM: tag lookup, hit access, and miss recovery
// (dirty-victim writeback, line allocate, install, replay).
// Also keeps saturating hit/miss/writeback statistics.
`timescale 1ns/1ps
module cache_controller #(
  parameter int LINE_SIZE  = 32,
  parameter int READ_ONLY  = 0,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cache_controller_if.slave     bus,
  input  logic                  valid_block_match,
  input  logic                  valid_dirty_bit,
  input  logic                  counter_done,
  output logic                  miss_recovery_mode,
  output logic                  set_hmem_block_address,
  output logic                  use_victim_tag_for_hmem_block_address,
  output logic                  clear_selected_valid_bit,
  output logic                  finish_new_line_install,
  output logic                  clear_selected_dirty_bit,
  output logic                  set_selected_dirty_bit,
  output logic                  perform_write,
  output logic                  reset_counter,
  output logic                  decrement_counter,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count,
  output logic [STAT_WIDTH-1:0] writeback_count
);

  localparam int WORDS_PER_LINE = LINE_SIZE / 4;
  localparam bit RO = (READ_ONLY != 0);

  // The external word counter needs at least one whole word per line.
  if (WORDS_PER_LINE < 1 || (LINE_SIZE % 4) != 0) begin : g_bad_line_size
    $error("cache_controller: LINE_SIZE must be a positive multiple of 4");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   replay_q, replay_d;
  logic   op_q, op_d;
  logic   inc_hit, inc_miss, inc_wb;
  logic   req_done_c, hmem_valid_c, hmem_op_c;

  assign bus.req_done       = req_done_c;
  assign bus.hmem_req_valid = hmem_valid_c;
  assign bus.hmem_req_op    = hmem_op_c;

  // State, latched request op and replay flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      replay_q <= 1'b0;
      op_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      replay_q <= replay_d;
      op_q     <= op_d;
    end
  end

  // Next state and all control strobes; hmem_req_done only counts in
  // the two states that hold hmem_req_valid high.
  always_comb begin
    state_d                               = state_q;
    replay_d                              = replay_q;
    op_d                                  = op_q;
    req_done_c                            = 1'b0;
    hmem_valid_c                          = 1'b0;
    hmem_op_c                             = 1'b0;
    miss_recovery_mode                    = 1'b0;
    set_hmem_block_address                = 1'b0;
    use_victim_tag_for_hmem_block_address = 1'b0;
    clear_selected_valid_bit              = 1'b0;
    finish_new_line_install               = 1'b0;
    clear_selected_dirty_bit              = 1'b0;
    set_selected_dirty_bit                = 1'b0;
    perform_write                         = 1'b0;
    reset_counter                         = 1'b0;
    decrement_counter                     = 1'b0;
    inc_hit                               = 1'b0;
    inc_miss                              = 1'b0;
    inc_wb                                = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        replay_d = 1'b0;
        if (valid_block_match) begin
          req_done_c = 1'b1;
          if (op_q && !RO) begin
            perform_write          = 1'b1;
            set_selected_dirty_bit = 1'b1;
          end
          inc_hit = !replay_q;
          state_d = IDLE;
        end else begin
          // A miss on replay is recovered again but not recounted.
          inc_miss               = !replay_q;
          set_hmem_block_address = 1'b1;
          reset_counter          = 1'b1;
          if (valid_dirty_bit && !RO) begin
            use_victim_tag_for_hmem_block_address = 1'b1;
            state_d                               = WRITEBACK;
          end else begin
            clear_selected_valid_bit = 1'b1;
            state_d                  = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        miss_recovery_mode = 1'b1;
        hmem_valid_c       = 1'b1;
        hmem_op_c          = 1'b1;
        if (bus.hmem_req_done) begin
          if (!counter_done) begin
            decrement_counter = 1'b1;
          end else begin
            clear_selected_dirty_bit = 1'b1;
            set_hmem_block_address   = 1'b1;
            reset_counter            = 1'b1;
            clear_selected_valid_bit = 1'b1;
            inc_wb                   = 1'b1;
            state_d                  = ALLOCATE;
          end
        end
      end
      ALLOCATE: begin
        miss_recovery_mode = 1'b1;
        hmem_valid_c       = 1'b1;
        if (bus.hmem_req_done) begin
          perform_write = 1'b1;
          if (!counter_done) begin
            decrement_counter = 1'b1;
          end else begin
            finish_new_line_install = 1'b1;
            replay_d                = 1'b1;
            state_d                 = LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count       <= '0;
      miss_count      <= '0;
      writeback_count <= '0;
    end else begin
      if (inc_hit && hit_count != '1)        hit_count       <= hit_count + 1'b1;
      if (inc_miss && miss_count != '1)      miss_count      <= miss_count + 1'b1;
      if (inc_wb && writeback_count != '1)   writeback_count <= writeback_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench: the driver pushes per-request expectations derived
// from the request kind (hit / clean miss / dirty miss, hmem wait) and
// a monitor counts what the controller does and compares on req_done.
`timescale 1ns/1ps
module tb_cache_controller;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_controller_if bus();
  cache_controller_if ro_bus();

  // main instance datapath-facing signals
  logic vbm, vdb, cdone;
  logic mrm, sha, usev, clrv, fin, cdirty, sdirty, pw, rstc, dec;
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;

  // read-only, 2-bit statistics instance
  logic r_mrm, r_sha, r_usev, r_clrv, r_fin, r_cdirty, r_sdirty, r_pw, r_rstc, r_dec;
  logic [1:0] r_hit, r_miss, r_wb;

  cache_controller #(.LINE_SIZE(32), .READ_ONLY(0), .STAT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .valid_block_match(vbm), .valid_dirty_bit(vdb), .counter_done(cdone),
    .miss_recovery_mode(mrm), .set_hmem_block_address(sha),
    .use_victim_tag_for_hmem_block_address(usev),
    .clear_selected_valid_bit(clrv), .finish_new_line_install(fin),
    .clear_selected_dirty_bit(cdirty), .set_selected_dirty_bit(sdirty),
    .perform_write(pw), .reset_counter(rstc), .decrement_counter(dec),
    .hit_count(hit_cnt), .miss_count(miss_cnt), .writeback_count(wb_cnt)
  );

  cache_controller #(.LINE_SIZE(32), .READ_ONLY(1), .STAT_WIDTH(2)) dut_ro (
    .clk(clk), .reset_n(reset_n), .bus(ro_bus),
    .valid_block_match(1'b1), .valid_dirty_bit(1'b0), .counter_done(1'b1),
    .miss_recovery_mode(r_mrm), .set_hmem_block_address(r_sha),
    .use_victim_tag_for_hmem_block_address(r_usev),
    .clear_selected_valid_bit(r_clrv), .finish_new_line_install(r_fin),
    .clear_selected_dirty_bit(r_cdirty), .set_selected_dirty_bit(r_sdirty),
    .perform_write(r_pw), .reset_counter(r_rstc), .decrement_counter(r_dec),
    .hit_count(r_hit), .miss_count(r_miss), .writeback_count(r_wb)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int lat, wr, rd, pw, dec, fin, cdirty, sdirty, sha_v, sha_r, clrv, rstc;
    int hit, miss, wb;
  } exp_t;
  exp_t sb[$];

  // Stimulus knobs for the environment, written only by the driver.
  bit txn_hit, txn_dirty;
  int txn_wt;
  int exp_hit, exp_miss, exp_wb;

  // External word counter.
  int cnt_m;
  always @(posedge clk or negedge reset_n)
    if (!reset_n)  cnt_m <= 0;
    else if (rstc) cnt_m <= W - 1;
    else if (dec)  cnt_m <= cnt_m - 1;
  assign cdone = (cnt_m == 0);

  // Tag array stand-in: the line becomes present once installed.
  logic installed;
  always @(posedge clk or negedge reset_n)
    if (!reset_n)            installed <= 1'b0;
    else if (fin)            installed <= 1'b1;
    else if (!bus.req_valid) installed <= 1'b0;
  assign vbm = txn_hit || installed;
  assign vdb = txn_dirty;

  // Higher memory: each word takes txn_wt stall cycles (0 = same cycle).
  int wcnt = 0;
  initial begin
    bus.hmem_req_done = 1'b0;
    ro_bus.hmem_req_done = 1'b0;
  end
  always @(posedge clk) begin
    if (bus.hmem_req_valid && bus.hmem_req_done) wcnt = 0;
    else if (bus.hmem_req_valid)                 wcnt++;
    else                                         wcnt = 0;
    #1;
    bus.hmem_req_done = reset_n && bus.hmem_req_valid && (wcnt == txn_wt);
  end

  // Monitor: counts controller activity per request, compares on req_done,
  // statistics one cycle later.
  bit busy = 0, stat_pend = 0;
  int lat, c_wr, c_rd, c_pw, c_dec, c_fin, c_cd, c_sd, c_shav, c_shar, c_clrv, c_rstc;
  exp_t last;
  always @(negedge clk) begin
    if (!reset_n) begin
      busy = 0;
      stat_pend = 0;
    end else begin
      if (stat_pend) begin
        chk("hit_count", int'(hit_cnt), last.hit);
        chk("miss_count", int'(miss_cnt), last.miss);
        chk("writeback_count", int'(wb_cnt), last.wb);
        stat_pend = 0;
      end
      if (busy) begin
        lat++;
        if (bus.hmem_req_valid && bus.hmem_req_done &&  bus.hmem_req_op) c_wr++;
        if (bus.hmem_req_valid && bus.hmem_req_done && !bus.hmem_req_op) c_rd++;
        c_pw += int'(pw);  c_dec += int'(dec); c_fin += int'(fin);
        c_cd += int'(cdirty); c_sd += int'(sdirty); c_clrv += int'(clrv);
        c_rstc += int'(rstc);
        c_shav += int'(sha && usev);
        c_shar += int'(sha && !usev);
        if (bus.req_done) begin
          busy = 0;
          if (sb.size() == 0) begin
            chk("unexpected_req_done", 1, 0);
          end else begin
            last = sb.pop_front();
            chk("latency", lat, last.lat);
            chk("hmem_writes", c_wr, last.wr);
            chk("hmem_reads", c_rd, last.rd);
            chk("perform_write", c_pw, last.pw);
            chk("decrement_counter", c_dec, last.dec);
            chk("finish_install", c_fin, last.fin);
            chk("clear_dirty", c_cd, last.cdirty);
            chk("set_dirty", c_sd, last.sdirty);
            chk("hmem_addr_victim", c_shav, last.sha_v);
            chk("hmem_addr_request", c_shar, last.sha_r);
            chk("clear_valid", c_clrv, last.clrv);
            chk("reset_counter", c_rstc, last.rstc);
            stat_pend = 1;
          end
        end
      end else if (bus.req_valid) begin
        busy = 1;
        lat = 0; c_wr = 0; c_rd = 0; c_pw = 0; c_dec = 0; c_fin = 0;
        c_cd = 0; c_sd = 0; c_shav = 0; c_shar = 0; c_clrv = 0; c_rstc = 0;
      end
    end
  end

  // Reference model: cost of one request from its kind alone.
  task automatic issue(input bit op, input bit hit, input bit dirty, input int wt);
    exp_t e;
    int   k;
    int   s = wt + 1;
    e = '{default: 0};
    if (hit) begin
      e.lat = 1; e.pw = op; e.sdirty = op;
      exp_hit++;
    end else begin
      exp_miss++;
      e.rd = W; e.pw = W + op; e.fin = 1; e.sdirty = op;
      e.sha_r = 1; e.clrv = 1;
      if (dirty) begin
        e.lat = 2 * W * s + 2; e.wr = W; e.dec = 2 * (W - 1);
        e.cdirty = 1; e.sha_v = 1; e.rstc = 2;
        exp_wb++;
      end else begin
        e.lat = W * s + 2; e.dec = W - 1; e.rstc = 1;
      end
    end
    e.hit = exp_hit; e.miss = exp_miss; e.wb = exp_wb;
    sb.push_back(e);
    txn_hit = hit; txn_dirty = dirty; txn_wt = wt;
    bus.req_op = op;
    bus.req_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.req_done && k < 2000);
    bus.req_valid = 1'b0;
    if (k >= 2000) chk("req_done_timeout", k, e.lat);
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 1'b0;
    ro_bus.req_valid = 1'b0; ro_bus.req_op = 1'b0;
    txn_hit = 0; txn_dirty = 0; txn_wt = 0;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_done", int'(bus.req_done), 0);
    chk("reset_hmem_valid", int'(bus.hmem_req_valid), 0);
    chk("reset_stats", int'(hit_cnt) + int'(miss_cnt) + int'(wb_cnt), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // directed: load hit, store hit, clean load miss, dirty store miss
    issue(1'b0, 1'b1, 1'b0, 0);
    issue(1'b1, 1'b1, 1'b0, 0);
    issue(1'b0, 1'b0, 1'b0, 0);
    issue(1'b1, 1'b0, 1'b1, 2);

    // randomized mix
    for (int i = 0; i < 40; i++)
      issue(1'($urandom % 2), ($urandom % 3) == 0, 1'($urandom % 2), int'($urandom % 3));

    // reset during the 4th allocate word of a clean miss
    txn_hit = 0; txn_dirty = 0; txn_wt = 0;
    bus.req_op = 1'b0;
    bus.req_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("in_allocate_before_reset", int'(bus.hmem_req_valid && !bus.hmem_req_op), 1);
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("reset_outputs_zero",
        int'(bus.req_done) + int'(bus.hmem_req_valid) + int'(mrm) + int'(sha) +
        int'(usev) + int'(clrv) + int'(fin) + int'(cdirty) + int'(sdirty) +
        int'(pw) + int'(rstc) + int'(dec), 0);
    chk("reset_stats_zero", int'(hit_cnt) + int'(miss_cnt) + int'(wb_cnt), 0);
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 1'b1, 1);
    issue(1'b0, 1'b1, 1'b0, 0);

    // read-only instance: store hits never write; 2-bit hit count saturates
    for (int i = 0; i < 5; i++) begin
      ro_bus.req_op = (i % 2 == 0);
      ro_bus.req_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ro_req_done", int'(ro_bus.req_done), 1);
      chk("ro_no_write", int'(r_pw) + int'(r_sdirty) + int'(ro_bus.hmem_req_valid), 0);
      ro_bus.req_valid = 1'b0;
      @(negedge clk);
      chk("ro_hit_count", int'(r_hit), (i + 1 > 3) ? 3 : i + 1);
      @(posedge clk); #1;
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
